// File: rtl/ch_burst_mux_pkg.sv
// ch_burst_mux_pkg
//   Shared definitions for the burst multiplexer and the arbiter-side helpers:
//   FSM state encoding, default parameter values, header tag constant and
//   the one-hot encoder geometry.
//   Optional feature macro referenced by users of this package: CH_HEADER_EN.
package ch_burst_mux_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LATCH = 3'd1,
        S_HDR   = 3'd2,
        S_XFER  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int NCH_DEF       = 16;
    localparam int DW_DEF        = 16;
    localparam int BURST_LEN_DEF = 256;
    localparam int CW_DEF        = 9;

    // Tag placed in the top nibble of a burst header word.
    localparam logic [3:0] HDR_TAG = 4'hA;

    // Geometry of the shared one-hot encoder.
    localparam int ENC_W = 16;
    localparam int IDX_W = 4;

    // A burst is "in progress" from LATCH up to and including FLUSH.
    function automatic logic is_busy(input state_t s);
        return (s == S_LATCH) || (s == S_HDR) || (s == S_XFER) || (s == S_FLUSH);
    endfunction

endpackage

// File: rtl/ch_burst_mux_onehot_enc16.sv
// onehot_enc16
//   Combinational 16-bit one-hot to binary index encoder with multi-hot
//   detection. Reused by several arbiter-side blocks.
//   Ports:
//     i_onehot  in  16  grant vector
//     o_idx     out 4   index of the set bit (highest set bit when multi-hot)
//     o_any     out 1   at least one bit set
//     o_multi   out 1   more than one bit set
module onehot_enc16
    import ch_burst_mux_pkg::*;
(
    input  logic [ENC_W-1:0] i_onehot,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any,
    output logic             o_multi
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < ENC_W; i++) begin
            if (i_onehot[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_onehot;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign o_multi = |(i_onehot & (i_onehot - ENC_W'(1)));

endmodule

// File: rtl/ch_burst_mux.sv
// ch_burst_mux
//   Moves one fixed-length burst from the granted channel's FWFT buffer into
//   the shared SDRAM write FIFO, then pulses Burst_done so the arbiter can
//   release and rotate its grant. Malformed (multi-hot) grants are flagged.
//   Optional feature macro: CH_HEADER_EN -- when defined, every burst is
//   preceded by one header word {HDR_TAG, Ch_id, zeros}.
//
//   Handshakes:
//     Channel side: Ch_rd[k] pops the FWFT head of channel k at the rising
//     edge; it is only asserted while Ch_valid[k] is high, so a read always
//     consumes a valid word.
//     FIFO side: Fifo_wr is a plain write enable with no ready; Fifo_afull
//     stops new reads in the same cycle, leaving at most one write in flight.
//
//   Ports:
//     Clk, Reset       clock, synchronous active-high reset
//     Gnt_in[NCH]      one-hot grant from the arbiter
//     Ch_valid[NCH]    per-channel FWFT not-empty
//     Ch_data[NCH*DW]  per-channel FWFT head words, channel k at [k*DW +: DW]
//     Ch_rd[NCH]       per-channel read strobe (one-hot or zero)
//     Fifo_afull       SDRAM FIFO almost-full
//     Fifo_wr, Fifo_din  SDRAM FIFO write port (registered)
//     Ch_id[4]         channel being served, valid while Busy
//     Busy             burst in progress
//     Burst_done       one-cycle pulse at the end of a burst
//     Gnt_err          pulse for a multi-hot grant seen in IDLE
//     o_dbg_state      current FSM state
module ch_burst_mux
    import ch_burst_mux_pkg::*;
#(
    parameter int NCH       = NCH_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [NCH-1:0]    Gnt_in,
    input  logic [NCH-1:0]    Ch_valid,
    input  logic [NCH*DW-1:0] Ch_data,
    output logic [NCH-1:0]    Ch_rd,
    input  logic              Fifo_afull,
    output logic              Fifo_wr,
    output logic [DW-1:0]     Fifo_din,
    output logic [3:0]        Ch_id,
    output logic              Busy,
    output logic              Burst_done,
    output logic              Gnt_err,
    output state_t            o_dbg_state
);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_ch_id;
    logic [CW-1:0]   r_cnt;
    logic            r_fifo_wr;
    logic [DW-1:0]   r_fifo_din;
    logic            r_gnt_err;

    logic [3:0]      w_gnt_idx;
    logic            w_gnt_any;
    logic            w_gnt_multi;
    logic            w_gnt_ok;
    logic            w_rd_en;
    logic            w_last_rd;
    logic [DW-1:0]   w_sel_word;
    logic            w_wr_en;
    logic [DW-1:0]   w_wr_data;

    onehot_enc16 u_enc (
        .i_onehot (Gnt_in),
        .o_idx    (w_gnt_idx),
        .o_any    (w_gnt_any),
        .o_multi  (w_gnt_multi)
    );

    assign w_gnt_ok   = w_gnt_any && !w_gnt_multi;
    assign w_sel_word = Ch_data[r_ch_id*DW +: DW];

    // A read needs data, FIFO room and an unfinished burst; the counter test
    // keeps the count saturated at BURST_LEN.
    assign w_rd_en   = (r_state == S_XFER) && Ch_valid[r_ch_id] && !Fifo_afull
                       && (r_cnt < CW'(BURST_LEN));
    assign w_last_rd = w_rd_en && (r_cnt == CW'(BURST_LEN - 1));

`ifdef CH_HEADER_EN
    logic w_hdr_wr;
    assign w_hdr_wr  = (r_state == S_HDR) && !Fifo_afull;
    assign w_wr_en   = w_rd_en || w_hdr_wr;
    assign w_wr_data = w_hdr_wr ? {HDR_TAG, r_ch_id, {(DW-8){1'b0}}} : w_sel_word;
`else
    assign w_wr_en   = w_rd_en;
    assign w_wr_data = w_sel_word;
`endif

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state; the grant is only looked at in IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_ok) begin
                    w_next = S_LATCH;
                end
            end
`ifdef CH_HEADER_EN
            S_LATCH: w_next = S_HDR;
            S_HDR: begin
                if (!Fifo_afull) begin
                    w_next = S_XFER;
                end
            end
`else
            S_LATCH: w_next = S_XFER;
`endif
            S_XFER: begin
                if (w_last_rd) begin
                    w_next = S_FLUSH;
                end
            end
            // The last read's registered write lands during FLUSH.
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Channel latch, burst counter, registered write port, error pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_ch_id    <= '0;
            r_cnt      <= '0;
            r_fifo_wr  <= 1'b0;
            r_fifo_din <= '0;
            r_gnt_err  <= 1'b0;
        end else begin
            r_gnt_err <= (r_state == S_IDLE) && w_gnt_multi;
            if ((r_state == S_IDLE) && w_gnt_ok) begin
                r_ch_id <= w_gnt_idx;
            end
            if (r_state == S_LATCH) begin
                r_cnt <= '0;
            end else if (w_rd_en) begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_fifo_wr <= w_wr_en;
            if (w_wr_en) begin
                r_fifo_din <= w_wr_data;
            end
        end
    end

    assign Ch_rd       = w_rd_en ? (NCH'(1) << r_ch_id) : '0;
    assign Fifo_wr     = r_fifo_wr;
    assign Fifo_din    = r_fifo_din;
    assign Ch_id       = r_ch_id;
    assign Busy        = is_busy(r_state);
    assign Burst_done  = (r_state == S_DONE);
    assign Gnt_err     = r_gnt_err;
    assign o_dbg_state = r_state;

endmodule

// File: doc/ch_burst_mux.md
Name: ch_burst_mux

Overview:
- Sits directly downstream of the 16-channel request/grant arbiter.
- Consumes the one-hot grant and moves one fixed-length burst from the granted channel's FWFT buffer into the shared SDRAM write FIFO.
- Emits a one-cycle burst-done pulse, which the arbiter uses to release the grant and rotate.
- Also reports the active channel ID and flags malformed grants.

Parameters:
- NCH, 16, number of channels (grant width).
- DW, 16, data word width.
- BURST_LEN, 256, words per burst (≥2).
- CW, 9, burst counter width; must satisfy 2^CW > BURST_LEN.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Gnt_in  in  NCH  one-hot grant from the arbiter.
- Ch_valid  in  NCH  per-channel FWFT buffer not-empty.
- Ch_data  in  NCH*DW  per-channel FWFT head word; channel k occupies bits [k*DW +: DW].
- Ch_rd  out  NCH  per-channel read strobe, one-hot or zero.
- Fifo_afull  in  1  SDRAM FIFO almost-full; asserts with ≥2 free entries remaining.
- Fifo_wr  out  1  SDRAM FIFO write enable.
- Fifo_din  out  DW  SDRAM FIFO write data.
- Ch_id  out  4  index of the channel being served; valid while Busy.
- Busy  out  1  burst in progress.
- Burst_done  out  1  one-cycle pulse at end of burst.
- Gnt_err  out  1  one-cycle pulse when a multi-hot grant is detected.

Behaviour:
- Reset (sync, high) clears everything: state=IDLE; Ch_rd=0, Fifo_wr=0, Fifo_din=0, Ch_id=0, Busy=0, Burst_done=0, Gnt_err=0, counter=0.
  - Reset mid-burst aborts immediately. No Burst_done is issued.
  - The partial burst stays in the FIFO; the upstream arbiter is reset by the same reset.
- FSM states: IDLE, LATCH, XFER, FLUSH, DONE.
  - IDLE:
    - Gnt_in==0: stay.
    - Exactly one bit set: encode its index into Ch_id; go to LATCH.
    - More than one bit set: pulse Gnt_err; stay IDLE; no reads.
  - LATCH: Busy=1, counter=0. Next state is XFER. Gnt_in is ignored from here until IDLE.
  - XFER:
    - Ch_rd[Ch_id]=1 in a cycle when Ch_valid[Ch_id]=1, Fifo_afull=0 and counter<BURST_LEN; the counter increments in the same cycle.
    - When the counter reaches BURST_LEN after a read, go to FLUSH.
  - FLUSH: one cycle for the final registered write to land; then go to DONE.
  - DONE: Burst_done=1 for one cycle, Busy=0; then return to IDLE.
- Data path is registered, 1-cycle latency:
  - Fifo_wr(t+1) = Ch_rd any-bit(t).
  - Fifo_din(t+1) = Ch_data word of Ch_id sampled at t.
  - Fifo_din holds its value when Fifo_wr=0.
- Backpressure:
  - Fifo_afull stalls reads in the same cycle.
  - At most one in-flight write exists after afull rises, so the 2-entry margin guarantees no overflow.
- Channel empty: a stall with no timeout; the burst resumes when Ch_valid returns.
- Grant dropping or changing during XFER has no effect; the arbiter must hold the grant until Burst_done.
- Grant present in the DONE cycle is not sampled. Earliest new grant acceptance is the first IDLE cycle, so the minimum gap between bursts is 1 idle cycle.
- Simultaneous afull and empty: stall with no read.
- The counter never wraps: it is cleared in LATCH and saturates at BURST_LEN.
- Exactly BURST_LEN Fifo_wr pulses occur per burst without the optional feature.

Optional Feature:
- Macro: CH_HEADER_EN.
- Defined:
  - An extra HDR state between LATCH and XFER writes one header word (no channel read that cycle): Fifo_din = {4'hA, Ch_id, zero-fill to DW}.
  - HDR waits while Fifo_afull=1.
  - A burst produces BURST_LEN+1 writes.
- Undefined: HDR state and its logic are absent, and LATCH goes straight to XFER.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, LATCH, HDR, XFER, FLUSH, DONE);
  - NCH/DW/BURST_LEN defaults;
  - header tag constant 4'hA.
- One natural sub-module: onehot_enc16 (combinational one-hot to index, plus multi-hot detect). It is reused by other arbiter-side blocks.

Test Plan:
1. Gnt_in=16'h0008, Ch_valid=all 1, afull=0, BURST_LEN=4 -> Ch_id=3; 4 consecutive Ch_rd[3] pulses; Fifo_din equals channel-3 words 1..4, each one cycle after its read; Burst_done pulses exactly once, 2 cycles after the last read.
2. Gnt_in=16'h0011 -> Gnt_err pulse, no Ch_rd, Busy stays 0; then 16'h0010 -> normal burst on ch4.
3. Mid-burst afull=1 for 5 cycles -> no Ch_rd during stall, ≤1 trailing Fifo_wr after assertion, total writes still 4.
4. Ch_valid[3] drops for 3 cycles after word 2 -> stall, resume, correct order; Gnt_in changed to 16'h0001 during burst -> ignored, Ch_id remains 3.
5. Reset asserted after word 2 -> next cycle all outputs are 0, state IDLE, no Burst_done; new grant then accepted normally.
6. CH_HEADER_EN defined, Gnt_in=16'h8000 -> first write is 16'hAF00, followed by 4 data writes, Burst_done once.
